vga_layer_mixer: RTL and testbench

- Final video stage in the 108 MHz dot-clock domain. Replaces the ad-hoc OR of the draw, text, medres and sprite layers ahead of the VGA IOB flops.
- Aligns the sync and active signals from the timing generator with the layer pipelines, then composites the layers (OR mode or priority mode).
- Applies a frame-synchronous fade-in/fade-out brightness FSM.
- Drives registered Hsync/Vsync/RGB to the pins.

---
 rtl/vga_pkg.sv | 23 ++
 rtl/vga_fade_fsm.sv | 59 +++++
 rtl/vga_layer_mixer.sv | 82 ++++++++
 tb/tb_vga_layer_mixer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared widths, layer indices, fade states and brightness scaling for the VGA output stage
package vga_pkg;
   localparam int RGB_W = 12;
   localparam int CH_W = 4;
   localparam int LYR_DRAW = 0;
   localparam int LYR_MEDRES = 1;
   localparam int LYR_TEXT = 2;
   localparam int LYR_SPRITE = 3;
   localparam logic [1:0] OPEN = 2'd0;
   localparam logic [1:0] FADE_OUT = 2'd1;
   localparam logic [1:0] DARK = 2'd2;
   localparam logic [1:0] FADE_IN = 2'd3;
   typedef logic [RGB_W-1:0] rgb_t;
   // (c * (b + 1)) >> 4: b = 15 is identity, b = 0 is black
   function automatic logic [CH_W-1:0] scale_ch(input logic [CH_W-1:0] c, input logic [3:0] b);
      logic [8:0] p;
      p = {5'd0, c} * ({5'd0, b} + 9'd1);
      return p[7:4];
   endfunction
   function automatic rgb_t scale_rgb(input rgb_t c, input logic [3:0] b);
      return {scale_ch(c[11:8], b), scale_ch(c[7:4], b), scale_ch(c[3:0], b)};
   endfunction
endpackage

// File: rtl/vga_fade_fsm.sv
// vga_fade_fsm: frame tick, frame counter and frame-synchronous fade-in/fade-out brightness control
module vga_fade_fsm
   import vga_pkg::*;
#(
   parameter logic VS_POL = 1'b1,
   parameter int FADE_RATE = 2
) (
   input logic clk_dot,
   input logic reset,
   input logic vs_d,
   input logic fade_req,
   output logic [3:0] bright,
   output logic fade_busy,
   output logic [15:0] frame_cnt
);
   logic vs_q, tick, step;
   logic [1:0] state, state_nxt;
   logic [3:0] bright_nxt;
   logic [7:0] div;
   assign tick = (vs_d == VS_POL) && (vs_q != VS_POL);
   assign step = tick && (div == 8'(FADE_RATE - 1));
   assign fade_busy = (state == FADE_OUT) || (state == FADE_IN);
   // a reversal of fade_req takes priority over a coincident step
   always_comb begin
      state_nxt = state;
      bright_nxt = bright;
      case (state)
         OPEN: state_nxt = fade_req ? FADE_OUT : OPEN;
         FADE_OUT:
            if (!fade_req) state_nxt = FADE_IN;
            else if (step) begin
               bright_nxt = (bright == 4'd0) ? 4'd0 : bright - 4'd1;
               state_nxt = (bright <= 4'd1) ? DARK : FADE_OUT;
            end
         DARK: state_nxt = fade_req ? DARK : FADE_IN;
         default:
            if (fade_req) state_nxt = FADE_OUT;
            else if (step) begin
               bright_nxt = (bright == 4'd15) ? 4'd15 : bright + 4'd1;
               state_nxt = (bright >= 4'd14) ? OPEN : FADE_IN;
            end
      endcase
   end
   always_ff @(posedge clk_dot) begin
      if (reset) begin
         state <= OPEN;
         bright <= 4'd15;
         div <= '0;
         frame_cnt <= '0;
         vs_q <= VS_POL;
      end else begin
         state <= state_nxt;
         bright <= bright_nxt;
         vs_q <= vs_d;
         frame_cnt <= frame_cnt + 16'(tick);
         div <= (state_nxt != state || step) ? 8'd0 : tick ? div + 8'd1 : div;
      end
   end
endmodule

// File: rtl/vga_layer_mixer.sv
// vga_layer_mixer: aligns sync/active with the layer pipelines, composites layers, applies fade
// brightness and registers Hsync/Vsync/RGB for the IOB flops
module vga_layer_mixer
   import vga_pkg::*;
#(
   parameter int SYNC_DLY = 2,
   parameter logic VS_POL = 1'b1,
   parameter logic SYNC_IDLE = 1'b0,
   parameter int FADE_RATE = 2
) (
   input logic clk_dot,
   input logic reset,
   input logic vga_hsync,
   input logic vga_vsync,
   input logic vid_active,
   input logic [RGB_W-1:0] rgb_draw,
   input logic [RGB_W-1:0] rgb_medres,
   input logic [RGB_W-1:0] rgb_text,
   input logic [RGB_W-1:0] rgb_sprite,
   input logic [3:0] layer_en,
   input logic mix_mode,
   input logic [RGB_W-1:0] bg_rgb,
   input logic fade_req,
   output logic hsync_out,
   output logic vsync_out,
   output logic [RGB_W-1:0] rgb_out,
   output logic [3:0] bright,
   output logic fade_busy,
   output logic [15:0] frame_cnt
);
   logic [2:0] sync_sr [SYNC_DLY];
   logic hs_d, vs_d, act_d, hs_a, vs_a;
   rgb_t lyr [4];
   rgb_t or_mix, pri_mix, mix, mix_a;
   assign {hs_d, vs_d, act_d} = sync_sr[SYNC_DLY-1];
   assign lyr[LYR_DRAW] = rgb_draw;
   assign lyr[LYR_MEDRES] = rgb_medres;
   assign lyr[LYR_TEXT] = rgb_text;
   assign lyr[LYR_SPRITE] = rgb_sprite;
   // ascending scan so the highest-priority opaque layer is the last to win
   always_comb begin
      or_mix = '0;
      pri_mix = bg_rgb;
      for (int i = 0; i < 4; i++) begin
         or_mix = or_mix | (layer_en[i] ? lyr[i] : '0);
         pri_mix = (layer_en[i] && lyr[i] != '0) ? lyr[i] : pri_mix;
      end
   end
   assign mix = !act_d ? '0 : mix_mode ? pri_mix : or_mix;
   always_ff @(posedge clk_dot) begin
      if (reset) begin
         for (int i = 0; i < SYNC_DLY; i++) sync_sr[i] <= '0;
         mix_a <= '0;
         hs_a <= SYNC_IDLE;
         vs_a <= SYNC_IDLE;
         hsync_out <= SYNC_IDLE;
         vsync_out <= SYNC_IDLE;
         rgb_out <= '0;
      end else begin
         sync_sr[0] <= {vga_hsync, vga_vsync, vid_active};
         for (int i = 1; i < SYNC_DLY; i++) sync_sr[i] <= sync_sr[i-1];
         mix_a <= mix;
         hs_a <= hs_d;
         vs_a <= vs_d;
         hsync_out <= hs_a;
         vsync_out <= vs_a;
         rgb_out <= scale_rgb(mix_a, bright);
      end
   end
   vga_fade_fsm #(
      .VS_POL(VS_POL),
      .FADE_RATE(FADE_RATE)
   ) u_fade (
      .clk_dot(clk_dot),
      .reset(reset),
      .vs_d(vs_d),
      .fade_req(fade_req),
      .bright(bright),
      .fade_busy(fade_busy),
      .frame_cnt(frame_cnt)
   );
endmodule

// File: tb/tb_vga_layer_mixer.sv
// tb_vga_layer_mixer: directed vector table for the compositor plus sequences for latency, fade and reset
module tb_vga_layer_mixer;
   logic clk_dot = 1'b0;
   logic reset = 1'b1;
   logic vga_hsync = 1'b0, vga_vsync = 1'b0, vid_active = 1'b0, mix_mode = 1'b0, fade_req = 1'b0;
   logic [11:0] rgb_draw = '0, rgb_medres = '0, rgb_text = '0, rgb_sprite = '0, bg_rgb = '0;
   logic [3:0] layer_en = '0;
   logic hsync_out, vsync_out, fade_busy;
   logic [11:0] rgb_out;
   logic [3:0] bright;
   logic [15:0] frame_cnt;
   int checks = 0;
   int failures = 0;
   int exp_fc = 0;
   typedef struct packed {
      logic [3:0] en;
      logic mode;
      logic [11:0] spr, txt, med, drw, bg, exp;
   } vec_t;
   vec_t vecs [11];

   vga_layer_mixer #(.SYNC_DLY(2), .VS_POL(1'b1), .SYNC_IDLE(1'b0), .FADE_RATE(2)) dut (
      .clk_dot(clk_dot), .reset(reset), .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
      .vid_active(vid_active), .rgb_draw(rgb_draw), .rgb_medres(rgb_medres), .rgb_text(rgb_text),
      .rgb_sprite(rgb_sprite), .layer_en(layer_en), .mix_mode(mix_mode), .bg_rgb(bg_rgb),
      .fade_req(fade_req), .hsync_out(hsync_out), .vsync_out(vsync_out), .rgb_out(rgb_out),
      .bright(bright), .fade_busy(fade_busy), .frame_cnt(frame_cnt)
   );

   always #5 clk_dot = ~clk_dot;

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk_dot);
         #1;
      end
   endtask

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", nm, act, exp);
      end
   endtask

   task automatic frame();
      vga_vsync = 1'b1;
      step(4);
      chk("vsync_lat", 16'(vsync_out), 16'd1);
      vga_vsync = 1'b0;
      step(4);
      exp_fc++;
   endtask

   task automatic frames(input int n);
      repeat (n) frame();
   endtask

   initial begin
      vecs[0]  = '{4'hF, 1'b1, 12'h000, 12'hF00, 12'h0F0, 12'h000, 12'h123, 12'hF00};
      vecs[1]  = '{4'hF, 1'b1, 12'h000, 12'h000, 12'h0F0, 12'h000, 12'h123, 12'h0F0};
      vecs[2]  = '{4'hF, 1'b1, 12'h000, 12'h000, 12'h000, 12'h000, 12'h123, 12'h123};
      vecs[3]  = '{4'hF, 1'b0, 12'h800, 12'h000, 12'h000, 12'h00F, 12'h123, 12'h80F};
      vecs[4]  = '{4'h1, 1'b0, 12'h800, 12'h000, 12'h000, 12'h00F, 12'h123, 12'h00F};
      vecs[5]  = '{4'h6, 1'b1, 12'hABC, 12'h000, 12'h0F0, 12'h00F, 12'h123, 12'h0F0};
      vecs[6]  = '{4'hF, 1'b1, 12'hABC, 12'hF00, 12'h0F0, 12'h00F, 12'h123, 12'hABC};
      vecs[7]  = '{4'h0, 1'b0, 12'hABC, 12'hF00, 12'h0F0, 12'h00F, 12'h123, 12'h000};
      vecs[8]  = '{4'h0, 1'b1, 12'hABC, 12'hF00, 12'h0F0, 12'h00F, 12'h456, 12'h456};
      vecs[9]  = '{4'hF, 1'b0, 12'h000, 12'h0F0, 12'h00F, 12'hF00, 12'h123, 12'hFFF};
      vecs[10] = '{4'h9, 1'b1, 12'h000, 12'hF00, 12'h0F0, 12'h00F, 12'h123, 12'h00F};

      step(3);
      chk("rst_hsync", 16'(hsync_out), 16'd0);
      chk("rst_vsync", 16'(vsync_out), 16'd0);
      chk("rst_rgb", 16'(rgb_out), 16'h000);
      chk("rst_bright", 16'(bright), 16'd15);
      chk("rst_busy", 16'(fade_busy), 16'd0);
      chk("rst_fcnt", frame_cnt, 16'd0);
      reset = 1'b0;
      vid_active = 1'b1;
      step(4);

      for (int i = 0; i < 11; i++) begin
         layer_en = vecs[i].en;
         mix_mode = vecs[i].mode;
         rgb_sprite = vecs[i].spr;
         rgb_text = vecs[i].txt;
         rgb_medres = vecs[i].med;
         rgb_draw = vecs[i].drw;
         bg_rgb = vecs[i].bg;
         step(2);
         chk($sformatf("vec%0d", i), 16'(rgb_out), 16'(vecs[i].exp));
      end

      layer_en = 4'hF; mix_mode = 1'b0;
      rgb_sprite = 12'h800; rgb_text = '0; rgb_medres = '0; rgb_draw = 12'h00F;
      step(2);
      vid_active = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         step(1);
         if (i == 1) vid_active = 1'b1;
         chk($sformatf("act_drop_c%0d", i), 16'(rgb_out), (i == 4) ? 16'h000 : 16'h80F);
      end
      vga_hsync = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         step(1);
         chk($sformatf("hsync_lat_c%0d", i), 16'(hsync_out), (i >= 4) ? 16'd1 : 16'd0);
      end

      for (int i = 0; i < 10; i++) begin
         vga_vsync = 1'b1;
         step(1);
         vga_vsync = 1'b0;
         step(1);
      end
      step(4);
      exp_fc += 10;
      chk("burst_fcnt", frame_cnt, 16'(exp_fc));
      chk("burst_bright", 16'(bright), 16'd15);

      layer_en = 4'h1; rgb_draw = 12'hFFF; rgb_sprite = '0;
      step(2);
      chk("full_rgb", 16'(rgb_out), 16'hFFF);
      fade_req = 1'b1;
      step(2);
      chk("fo_busy", 16'(fade_busy), 16'd1);
      frame();
      chk("fo_tick1", 16'(bright), 16'd15);
      frame();
      chk("fo_tick2", 16'(bright), 16'd14);
      frames(14);
      chk("fo_b7", 16'(bright), 16'd7);
      chk("fo_rgb7", 16'(rgb_out), 16'h777);
      frames(13);
      chk("fo_b1", 16'(bright), 16'd1);
      chk("fo_b1_busy", 16'(fade_busy), 16'd1);
      frame();
      chk("dark_b0", 16'(bright), 16'd0);
      chk("dark_busy", 16'(fade_busy), 16'd0);
      chk("dark_rgb", 16'(rgb_out), 16'h000);
      chk("fade_fcnt", frame_cnt, 16'(exp_fc));
      frame();
      chk("dark_hold", 16'(bright), 16'd0);

      reset = 1'b1;
      step(1);
      reset = 1'b0;
      exp_fc = 0;
      step(2);
      frames(12);
      chk("rev_b9", 16'(bright), 16'd9);
      frame();
      chk("rev_pre", 16'(bright), 16'd9);
      vga_vsync = 1'b1;
      step(2);
      fade_req = 1'b0;
      step(2);
      vga_vsync = 1'b0;
      step(4);
      exp_fc++;
      chk("rev_nostep", 16'(bright), 16'd9);
      chk("rev_busy", 16'(fade_busy), 16'd1);
      frame();
      chk("fi_tick1", 16'(bright), 16'd9);
      frame();
      chk("fi_tick2", 16'(bright), 16'd10);
      chk("rev_fcnt", frame_cnt, 16'(exp_fc));

      fade_req = 1'b1;
      step(2);
      frames(10);
      chk("mid_b5", 16'(bright), 16'd5);
      chk("mid_rgb", 16'(rgb_out), 16'h555);
      chk("mid_hsync", 16'(hsync_out), 16'd1);
      reset = 1'b1;
      step(1);
      chk("mrst_bright", 16'(bright), 16'd15);
      chk("mrst_busy", 16'(fade_busy), 16'd0);
      chk("mrst_rgb", 16'(rgb_out), 16'h000);
      chk("mrst_hsync", 16'(hsync_out), 16'd0);
      chk("mrst_vsync", 16'(vsync_out), 16'd0);
      chk("mrst_fcnt", frame_cnt, 16'd0);
      reset = 1'b0;
      fade_req = 1'b0;
      step(3);
      chk("recov_early", 16'(rgb_out), 16'h000);
      step(1);
      chk("recov_rgb", 16'(rgb_out), 16'hFFF);
      chk("recov_hsync", 16'(hsync_out), 16'd1);
      exp_fc = 0;
      frame();
      chk("recov_fcnt", frame_cnt, 16'(exp_fc));
      chk("recov_bright", 16'(bright), 16'd15);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
